// File: rtl/ppg_peak_detector.sv
// PPG beat detector: threshold, then track the candidate maximum until the signal drops by HYST, then a refractory hold.
// Define PPG_ADAPT_TH_EN to make the threshold track half the previous peak amplitude, never below TH_MIN.
module ppg_peak_detector #(
  parameter int Width       = 10,
  parameter int IBI_W       = 12,
  parameter int TH_MIN      = 100,
  parameter int HYST        = 20,
  parameter int REFRACT_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [Width-1:0] data_in,
  input  logic                    valid_in,
  output logic                    beat_valid,
  output logic        [IBI_W-1:0] ibi,
  output logic signed [Width-1:0] peak_amp
);

  localparam logic signed [Width-1:0] ThMin       = Width'(TH_MIN);
  localparam logic signed [Width:0]   HystW       = (Width+1)'(HYST);
  localparam logic        [7:0]       RefractInit = 8'(REFRACT_LEN);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic        [IBI_W-1:0] gap_reg, gap_next;
  logic        [IBI_W-1:0] cand_gap_reg, cand_gap_next;
  logic signed [Width-1:0] cand_amp_reg, cand_amp_next;
  logic        [7:0]       refract_reg, refract_next;
  logic                    first_reg, first_next;
  logic                    beat_reg, beat_next;
  logic        [IBI_W-1:0] ibi_reg, ibi_next;
  logic signed [Width-1:0] peak_amp_reg, peak_amp_next;

  logic                    accept;
  logic        [IBI_W-1:0] gap_inc;
  logic signed [Width-1:0] thr;
  logic signed [Width:0]   in_ext;
  logic signed [Width:0]   drop_limit;
  logic                    drop_ok;

  assign accept  = en & valid_in;
  assign gap_inc = (&gap_reg) ? gap_reg : gap_reg + IBI_W'(1);

  // One extra bit so cand_amp - HYST cannot wrap for candidates near the negative rail.
  assign in_ext     = {data_in[Width-1], data_in};
  assign drop_limit = {cand_amp_reg[Width-1], cand_amp_reg} - HystW;
  assign drop_ok    = (in_ext <= drop_limit);

`ifdef PPG_ADAPT_TH_EN
  logic signed [Width-1:0] last_amp_reg, last_amp_next;
  logic signed [Width-1:0] half_last;

  assign half_last = last_amp_reg >>> 1;
  assign thr       = (half_last > ThMin) ? half_last : ThMin;
`else
  assign thr = ThMin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SEARCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gap_next      = gap_reg;
    cand_gap_next = cand_gap_reg;
    cand_amp_next = cand_amp_reg;
    refract_next  = refract_reg;
    first_next    = first_reg;
    beat_next     = 1'b0;
    ibi_next      = ibi_reg;
    peak_amp_next = peak_amp_reg;
`ifdef PPG_ADAPT_TH_EN
    last_amp_next = last_amp_reg;
`endif
    if (accept) begin
      gap_next = gap_inc;
      case (state_reg)
        SEARCH: begin
          if (data_in > thr) begin
            cand_amp_next = data_in;
            cand_gap_next = gap_inc;
            state_next    = TRACK;
          end
        end
        TRACK: begin
          if (data_in > cand_amp_reg) begin
            cand_amp_next = data_in;
            cand_gap_next = gap_inc;
          end else if (drop_ok) begin
            // Re-base gap on the candidate maximum so the next interval is peak-to-peak.
            gap_next      = gap_inc - cand_gap_reg;
            state_next    = REFRACT;
            refract_next  = RefractInit;
            beat_next     = 1'b1;
            ibi_next      = first_reg ? '0 : cand_gap_reg;
            peak_amp_next = cand_amp_reg;
            first_next    = 1'b0;
`ifdef PPG_ADAPT_TH_EN
            last_amp_next = cand_amp_reg;
`endif
          end
        end
        REFRACT: begin
          refract_next = refract_reg - 8'd1;
          if (refract_reg <= 8'd1) begin
            refract_next = '0;
            state_next   = SEARCH;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_reg      <= '0;
      cand_gap_reg <= '0;
      cand_amp_reg <= '0;
      refract_reg  <= '0;
      first_reg    <= 1'b1;
      beat_reg     <= 1'b0;
      ibi_reg      <= '0;
      peak_amp_reg <= '0;
`ifdef PPG_ADAPT_TH_EN
      last_amp_reg <= '0;
`endif
    end else begin
      gap_reg      <= gap_next;
      cand_gap_reg <= cand_gap_next;
      cand_amp_reg <= cand_amp_next;
      refract_reg  <= refract_next;
      first_reg    <= first_next;
      beat_reg     <= beat_next;
      ibi_reg      <= ibi_next;
      peak_amp_reg <= peak_amp_next;
`ifdef PPG_ADAPT_TH_EN
      last_amp_reg <= last_amp_next;
`endif
    end
  end

  assign beat_valid = beat_reg;
  assign ibi        = ibi_reg;
  assign peak_amp   = peak_amp_reg;

endmodule

// File: tb/tb_ppg_peak_detector.sv
// Directed bench for ppg_peak_detector: one accepted sample every 4 clocks, hand-computed beats/ibi/amplitudes.
module tb_ppg_peak_detector;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic signed [9:0] data_in;
  logic              valid_in;
  logic              beat_valid;
  logic       [11:0] ibi;
  logic signed [9:0] peak_amp;

  int tests = 0;
  int fails = 0;
  int stray = 0;
  logic b;

  ppg_peak_detector dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .beat_valid(beat_valid),
    .ibi       (ibi),
    .peak_amp  (peak_amp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one sample for a single clock, captures beat_valid right after that edge, then idles 3 clocks.
  task automatic push(input int d, output logic got);
    data_in  = d[9:0];
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    got      = beat_valid;
    $display("[TB] t=%0t en=%0b sample=%0d beat=%0b ibi=%0d peak_amp=%0d", $time, en, d, got, ibi, peak_amp);
    repeat (3) begin
      @(negedge clk);
      if (beat_valid) stray++;
    end
  endtask

  task automatic push_chk(input int d, input int exp_beat, input string tag);
    logic g;
    push(d, g);
    chk(tag, {31'b0, g}, exp_beat);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_beat", {31'b0, beat_valid}, 0);
    chk("reset_ibi", {20'b0, ibi}, 0);
    chk("reset_peak", peak_amp, 0);

    // First pulse: maximum 200 at sample 3, confirmed by 170 (<= 180).
    push_chk(0, 0, "p1_s0");
    push_chk(50, 0, "p1_s1");
    push_chk(150, 0, "p1_s2");
    push_chk(200, 0, "p1_s3");
    push_chk(170, 1, "first_beat");
    chk("first_ibi", {20'b0, ibi}, 0);
    chk("first_peak", peak_amp, 200);

    // Refractory window: a rise to 300 inside these 8 samples must not produce a beat.
    push_chk(120, 0, "refract_0");
    chk("peak_hold", peak_amp, 200);
    push_chk(300, 0, "refract_rise300");
    push_chk(250, 0, "refract_2");
    push_chk(100, 0, "refract_3");
    push_chk(50, 0, "refract_4");
    for (int i = 0; i < 3; i++) push_chk(0, 0, "refract_tail");

    for (int i = 0; i < 17; i++) push_chk(0, 0, "idle");
    // Sample equal to threshold must not arm; 80 would confirm a 100 candidate.
    push_chk(100, 0, "thr_equal");
    push_chk(80, 0, "thr_equal_drop");

    // Second pulse: maximum 300 at sample 33, 30 samples after the first maximum.
    push_chk(150, 0, "p2_s0");
    push_chk(300, 0, "p2_max");
    push_chk(250, 1, "second_beat");
    chk("second_ibi", {20'b0, ibi}, 30);
    chk("second_peak", peak_amp, 300);
    for (int i = 0; i < 8; i++) push_chk(0, 0, "refract2");

    // Third pulse with en low mid-TRACK: gated samples must be invisible.
    push_chk(160, 0, "p3_s0");
    push_chk(220, 0, "p3_max");
    en = 1'b0;
    push_chk(500, 0, "en_low_big");
    for (int i = 0; i < 4; i++) push_chk(0, 0, "en_low_drop");
    en = 1'b1;
    push_chk(201, 0, "hyst_above");
    push_chk(200, 1, "hyst_edge");
    chk("third_ibi", {20'b0, ibi}, 11);
    chk("third_peak", peak_amp, 220);
    for (int i = 0; i < 8; i++) push_chk(0, 0, "refract3");

    push_chk(400, 0, "p4_max");
    push_chk(300, 1, "peak400_beat");
    chk("peak400_ibi", {20'b0, ibi}, 11);
    chk("peak400_peak", peak_amp, 400);
    for (int i = 0; i < 8; i++) push_chk(0, 0, "refract4");

`ifdef PPG_ADAPT_TH_EN
    push_chk(150, 0, "adapt_150_ignored");
    push_chk(120, 0, "adapt_120");
    push_chk(250, 0, "adapt_250_track");
    push_chk(200, 1, "adapt_beat");
    chk("adapt_ibi", {20'b0, ibi}, 12);
    chk("adapt_peak", peak_amp, 250);
`else
    push_chk(150, 0, "fixed_150_track");
    push_chk(120, 1, "fixed_beat");
    chk("fixed_ibi", {20'b0, ibi}, 10);
    chk("fixed_peak", peak_amp, 150);
    push_chk(250, 0, "fixed_refract_250");
    push_chk(200, 0, "fixed_refract_200");
`endif

    // Reset while tracking a 180 candidate, with a confirming sample presented in the same cycle.
    for (int i = 0; i < 10; i++) push_chk(0, 0, "pre_rst_idle");
    push_chk(180, 0, "track180");
    rst      = 1'b1;
    data_in  = '0;
    valid_in = 1'b1;
    @(negedge clk);
    chk("rst_priority_beat", {31'b0, beat_valid}, 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    chk("rst_ibi", {20'b0, ibi}, 0);
    chk("rst_peak", peak_amp, 0);
    repeat (3) @(negedge clk);
    push_chk(150, 0, "post_rst_s0");
    push_chk(190, 0, "post_rst_max");
    push_chk(160, 1, "post_rst_beat");
    chk("post_rst_ibi", {20'b0, ibi}, 0);
    chk("post_rst_peak", peak_amp, 190);

    chk("stray_beats", stray, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
